fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares one circular FIFO write port among NUM_REQ producers. It grants the port to one requester at a time, streams that requester's words into the FIFO in bursts of up to MAX_BURST, and respects the FIFO's `full` flag. It sits directly in front of the FIFO's `wr_en`/`input_data` pins. The read side is untouched.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `WIDTH`, 8: data word width; matches the FIFO data width.
- `MAX_BURST`, 4: maximum words per grant, 1..16.
- `ID_WIDTH`, 2: width of the owner index; equals clog2(NUM_REQ).
- `clk`, in, 1: the single clock; all state is updated on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req`, in, NUM_REQ: per-producer request; held high while the producer has data.
- `req_data`, in, NUM_REQ*WIDTH: producer i drives bits [i*WIDTH +: WIDTH].
- `ack`, out, NUM_REQ: one-hot; high in the cycle a producer's word is written. The producer advances its data on the next edge.
- `gnt`, out, NUM_REQ: one-hot registered grant; zero when idle.
- `busy`, out, 1: high in BURST state.
- `fifo_full`, in, 1: the FIFO `full` flag.
- `fifo_wr_en`, out, 1: FIFO write enable.
- `fifo_wr_data`, out, WIDTH: FIFO write data.

## Operation
- **States:** IDLE and BURST. Registered state: `owner`, `burst_cnt` (clog2(MAX_BURST)+1 bits), `last` (last-served index).
- **IDLE:**
  - If `req` is nonzero, pick the first set bit searching from (last+1) mod NUM_REQ upward, with wrap.
  - On that edge: set `owner` to the winner, set `gnt`, clear `burst_cnt`, go to BURST.
  - If `req` is zero, stay in IDLE with `gnt` = 0.
- **BURST, write condition:** `fifo_wr_en` = req[owner] & ~fifo_full. It is combinational from state and inputs.
  - `fifo_wr_data` = the owner's slice of `req_data` whenever in BURST.
  - `ack[owner]` = `fifo_wr_en`.
- **BURST, on each write edge:** increment `burst_cnt`.
  - If the new count equals MAX_BURST, go to IDLE, set `last` to `owner`, clear `gnt`.
- **BURST, on any edge with req[owner] low:**
  - Go to IDLE, set `last` to `owner`, clear `gnt`.
  - No write occurs on that edge.
- **BURST with fifo_full:** stall. Stay in BURST, no write, `burst_cnt` held, grant kept.
- **Rotation:** after a grant ends, the former owner has the lowest priority in the next arbitration. This bounds each producer's wait to (NUM_REQ-1) bursts plus bubbles.
- **Outputs in IDLE:** `fifo_wr_en`, `ack`, `gnt` and `busy` are 0. `fifo_wr_data` is 0.
- **Other requests during BURST:** requests from non-owners are ignored until the return to IDLE.

## Timing
- **Reset values:** state = IDLE, `gnt` = 0, `ack` = 0, `busy` = 0, `fifo_wr_en` = 0, `fifo_wr_data` = 0, `owner` = 0, `burst_cnt` = 0, `last` = NUM_REQ-1, so requester 0 has first priority.
- **Latency:** a request seen in IDLE at edge k produces `gnt`/`busy` after edge k. The first word is written at edge k+1 if not full.
- **Bubble:** there is exactly one IDLE cycle between consecutive grants.
- **Throughput:** a full burst takes MAX_BURST+1 cycles.
- **Reset asserted mid-burst:** all outputs drop immediately and asynchronously. The word in flight is not written; the FIFO is reset on the same line.
- **fifo_full rising in BURST:** `fifo_wr_en` drops in the same cycle, so there is no write into a full FIFO.
- **req[owner] dropping and fifo_full in the same cycle:** the exit rule wins and the state returns to IDLE.

## Structure
- **Shared package `fifo_pkg`:**
  - State encoding constants ST_IDLE = 1'b0, ST_BURST = 1'b1.
  - Default WIDTH/DEPTH constants, shared with the FIFO core.
- **Sub-module `rr_pick`:**
  - Purely combinational.
  - Inputs: `req[NUM_REQ]`, `last[ID_WIDTH]`.
  - Outputs: `winner[ID_WIDTH]`, `valid`.
  - Implemented as a rotate, a priority encode, then an un-rotate.
- **Top:** the arbiter top holds only the FSM, counters and output muxing.

## Test plan
- **Reset:** reset low with `req` = 4'b1111 -> all outputs 0. After release, the first grant goes to 0 (`gnt` = 4'b0001).
- **Single producer:** req = 4'b0100 held, data 0x10, 0x11, … advancing on `ack` -> 4 writes 0x10..0x13 on consecutive edges. `gnt` then drops for 1 cycle and re-grants 2.
- **Fairness:** req = 4'b1111 held continuously, MAX_BURST = 4 -> grant order 0, 1, 2, 3, 0. Each grant writes 4 words, and every 5th cycle is a bubble.
- **Full stall:** owner 1 mid-burst after 2 words, `fifo_full` held high 3 cycles -> `fifo_wr_en` = 0 and `burst_cnt` holds at 2. After full clears, exactly 2 more words are written.
- **Early release:** owner 3 drops `req` after 1 word -> return to IDLE. The next grant goes to 0, not 3, even if 3 re-requests.
- **Async reset mid-burst:** reset pulsed low between edges during BURST -> `fifo_wr_en`/`gnt` go to 0 immediately. After release, arbitration restarts with requester 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO core and its write-side arbiter.
package fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: rotate requests so the slot after 'last' sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last,
  output logic [ID_WIDTH-1:0] winner,
  output logic                valid
);

  // One extra bit so start + index never overflows before the modulo.
  localparam logic [ID_WIDTH:0] N_W = (ID_WIDTH+1)'(NUM_REQ);

  logic [ID_WIDTH:0]  start;
  logic [ID_WIDTH:0]  idx;
  logic [ID_WIDTH:0]  sum;
  logic [NUM_REQ-1:0] rot;

  // Rotate, priority-encode, un-rotate.
  always_comb begin
    start = {1'b0, last} + 1'b1;
    if (start >= N_W) start = '0;
    rot = NUM_REQ'({req, req} >> start);
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = (ID_WIDTH+1)'(i);
    end
    sum = idx + start;
    if (sum >= N_W) sum = sum - N_W;
    winner = ID_WIDTH'(sum);
    valid  = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single FIFO write port.
// One producer owns the port per grant, for up to MAX_BURST words.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int MAX_BURST = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_t          state;
  logic [ID_WIDTH-1:0] owner;
  logic [ID_WIDTH-1:0] last;
  logic [CNT_W-1:0]    burst_cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [ID_WIDTH-1:0] winner;
  logic                pick_valid;
  logic                owner_req;
  logic [WIDTH-1:0]    slices [NUM_REQ];
  logic [WIDTH-1:0]    owner_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_pick (
    .req   (req),
    .last  (last),
    .winner(winner),
    .valid (pick_valid)
  );

  // Split the packed producer bus and select the owner's request and word.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slices[i] = req_data[i*WIDTH +: WIDTH];
    end
    owner_req  = req[owner];
    owner_data = slices[owner];
    cnt_next   = burst_cnt + 1'b1;
  end

  // Write port: combinational so a rising full or falling request blocks the write in the same cycle.
  always_comb begin
    busy         = (state == ST_BURST);
    fifo_wr_en   = busy & owner_req & ~fifo_full;
    fifo_wr_data = busy ? owner_data : '0;
    ack          = '0;
    if (fifo_wr_en) ack[owner] = 1'b1;
  end

  // Arbitration FSM; a dropped owner request takes precedence over a full stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      last      <= ID_WIDTH'(NUM_REQ - 1);
      burst_cnt <= '0;
      gnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner     <= winner;
            gnt       <= NUM_REQ'(1) << winner;
            burst_cnt <= '0;
            state     <= ST_BURST;
          end else begin
            gnt <= '0;
          end
        end
        ST_BURST: begin
          if (!owner_req) begin
            last  <= owner;
            gnt   <= '0;
            state <= ST_IDLE;
          end else if (!fifo_full) begin
            burst_cnt <= cnt_next;
            if (cnt_next == MAX_CNT) begin
              last  <= owner;
              gnt   <= '0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: scenarios queue expected writes,
// a negedge monitor pops and compares every FIFO write.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;

  exp_t       sb[$];
  logic [7:0] pdata [NUM_REQ];
  int         n_tests = 0;
  int         n_fail  = 0;

  fifo_wr_arbiter #(
    .NUM_REQ  (4),
    .WIDTH    (8),
    .MAX_BURST(4),
    .ID_WIDTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .gnt         (gnt),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = pdata[i];
  endtask

  task automatic push_burst(input int idx, input logic [7:0] start, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.idx  = idx;
      e.data = start + 8'(k);
      sb.push_back(e);
    end
  endtask

  // One clock: sample ack after inputs settle, then let producers advance on the edge.
  task automatic tick();
    logic [NUM_REQ-1:0] a;
    #1;
    a = ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (a[i] && reset) pdata[i] = pdata[i] + 8'd1;
    drive_data();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (fifo_wr_en) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: write 0x%0h ack %b with nothing expected at %0t",
                 fifo_wr_data, ack, $time);
      end else begin
        e = sb.pop_front();
        check("wr_data", 32'(fifo_wr_data), 32'(e.data));
        check("wr_ack", 32'(ack), 32'(1) << e.idx);
      end
    end else begin
      check("ack_no_write", 32'(ack), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [NUM_REQ-1:0] exp_g;

    reset     = 1'b0;
    req       = 4'b1111;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pdata[i] = 8'h00;
    drive_data();

    // Reset state with all requests pending
    #3;
    check("rst_gnt",     32'(gnt), 32'd0);
    check("rst_ack",     32'(ack), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_wr_en",   32'(fifo_wr_en), 32'd0);
    check("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("first_gnt",  32'(gnt), 32'b0001);
    check("first_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    tick();
    check("release_gnt",  32'(gnt), 32'd0);
    check("release_busy", 32'(busy), 32'd0);

    // Single producer 2: four words then a one-cycle bubble and re-grant
    pdata[2] = 8'h10;
    drive_data();
    req = 4'b0100;
    push_burst(2, 8'h10, 4);
    tick();
    check("single_gnt", 32'(gnt), 32'b0100);
    for (int k = 0; k < 4; k++) tick();
    check("single_bubble", 32'(gnt), 32'd0);
    tick();
    check("single_regnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    tick();
    check("single_sb_empty", 32'(sb.size()), 32'd0);

    // Fairness: all requesting, order 0,1,2,3,0 with a bubble every 5th cycle
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) pdata[i] = 8'h40 + 8'(16 * i);
    drive_data();
    req = 4'b1111;
    push_burst(0, 8'h40, 4);
    push_burst(1, 8'h50, 4);
    push_burst(2, 8'h60, 4);
    push_burst(3, 8'h70, 4);
    push_burst(0, 8'h44, 4);
    for (int j = 1; j <= 25; j++) begin
      tick();
      exp_g = (j % 5 == 0) ? 4'b0000 : (4'b0001 << seq[(j - 1) / 5]);
      check("fair_gnt", 32'(gnt), 32'(exp_g));
    end
    req = 4'b0000;
    tick();
    check("fair_sb_empty", 32'(sb.size()), 32'd0);

    // Full stall: owner 1 after 2 words, full held 3 cycles
    pdata[1] = 8'h80;
    drive_data();
    req = 4'b0010;
    push_burst(1, 8'h80, 4);
    tick();
    check("stall_gnt", 32'(gnt), 32'b0010);
    tick();
    tick();
    fifo_full = 1'b1;
    #1;
    check("stall_wr_en_now", 32'(fifo_wr_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_wr_en", 32'(fifo_wr_en), 32'd0);
      check("stall_cnt", 32'(dut.burst_cnt), 32'd2);
      check("stall_gnt_held", 32'(gnt), 32'b0010);
    end
    fifo_full = 1'b0;
    tick();
    tick();
    check("stall_end_gnt", 32'(gnt), 32'd0);
    req = 4'b0000;
    check("stall_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // Early release by owner 3, with full rising on the same cycle
    pdata[3] = 8'h90;
    drive_data();
    req = 4'b1000;
    push_burst(3, 8'h90, 1);
    tick();
    check("early_gnt", 32'(gnt), 32'b1000);
    tick();
    req = 4'b0000;
    fifo_full = 1'b1;
    tick();
    check("early_busy", 32'(busy), 32'd0);
    check("early_gnt_off", 32'(gnt), 32'd0);
    fifo_full = 1'b0;
    req = 4'b1001;
    tick();
    check("early_next_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    tick();
    check("early_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of a burst
    pdata[2] = 8'hB0;
    drive_data();
    req = 4'b0100;
    push_burst(2, 8'hB0, 1);
    tick();
    check("arst_gnt", 32'(gnt), 32'b0100);
    tick();
    #1;
    check("arst_pre_wr_en", 32'(fifo_wr_en), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_wr_en",   32'(fifo_wr_en), 32'd0);
    check("arst_gnt_off", 32'(gnt), 32'd0);
    check("arst_busy",    32'(busy), 32'd0);
    check("arst_wr_data", 32'(fifo_wr_data), 32'd0);
    reset = 1'b1;
    req = 4'b1111;
    tick();
    check("arst_restart_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    tick();
    tick();
    check("arst_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
